// File: rtl/multicycle_sequencer_if.sv
// Memory handshake bundle between the multi-cycle sequencer and the
// instruction/data memories.
interface multicycle_sequencer_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ready,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ready,
    output dmem_ready
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle SimpleRisc control FSM: steps FETCH/DECODE/EXEC/MEM/WB, drives
// datapath strobes, traps memory timeouts and counts retired instructions.
module multicycle_sequencer #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_run,
  input  logic                   i_is_ld,
  input  logic                   i_is_st,
  input  logic                   i_is_wb,
  input  logic                   i_is_beq,
  input  logic                   i_is_bgt,
  input  logic                   i_is_ubranch,
  input  logic                   i_is_call,
  input  logic                   i_is_ret,
  input  logic                   i_flag_eq,
  input  logic                   i_flag_gt,
  multicycle_sequencer_if.master mem_if,
  output logic                   o_ir_we,
  output logic                   o_alu_en,
  output logic                   o_rf_we,
  output logic [1:0]             o_wb_sel,
  output logic                   o_pc_we,
  output logic [1:0]             o_pc_sel,
  output logic                   o_busy,
  output logic                   o_err,
  output logic [CNT_W-1:0]       o_retired_cnt
);

  localparam int unsigned        WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [1:0]         WB_ALU    = 2'd0;
  localparam logic [1:0]         WB_MEM    = 2'd1;
  localparam logic [1:0]         WB_PC4    = 2'd2;
  localparam logic [1:0]         PC_SEQ    = 2'd0;
  localparam logic [1:0]         PC_BR     = 2'd1;
  localparam logic [1:0]         PC_RET    = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERR
  } state_e;

  typedef struct packed {
    logic ld;
    logic st;
    logic wb;
    logic beq;
    logic bgt;
    logic ubr;
    logic call;
    logic ret;
  } ctl_t;

  state_e             r_state, w_state_nxt;
  logic [WAIT_W-1:0]  r_wait, w_wait_nxt;
  ctl_t               r_ctl, w_ctl_nxt, w_ctl_in;
  logic [CNT_W-1:0]   r_retired_cnt;
  logic               r_err;
  logic               w_taken;

  assign w_ctl_in = '{ld: i_is_ld, st: i_is_st, wb: i_is_wb, beq: i_is_beq,
                      bgt: i_is_bgt, ubr: i_is_ubranch, call: i_is_call,
                      ret: i_is_ret};

  // Unconditional branch only counts when no conditional branch is decoded.
  assign w_taken = r_ctl.call | r_ctl.ret | (r_ctl.beq & i_flag_eq) |
                   (r_ctl.bgt & i_flag_gt) |
                   (r_ctl.ubr & ~r_ctl.beq & ~r_ctl.bgt);

  always_comb begin
    w_state_nxt     = r_state;
    w_wait_nxt      = '0;
    w_ctl_nxt       = r_ctl;
    o_ir_we         = 1'b0;
    o_alu_en        = 1'b0;
    o_rf_we         = 1'b0;
    o_wb_sel        = WB_ALU;
    o_pc_we         = 1'b0;
    o_pc_sel        = PC_SEQ;
    mem_if.imem_req = 1'b0;
    mem_if.dmem_req = 1'b0;
    mem_if.dmem_we  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_run) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        mem_if.imem_req = 1'b1;
        if (mem_if.imem_ready) begin
          o_ir_we     = 1'b1;
          w_state_nxt = S_DECODE;
        end else if (r_wait == WAIT_LAST) begin
          w_state_nxt = S_ERR;
        end else begin
          w_wait_nxt = r_wait + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        w_ctl_nxt   = w_ctl_in;
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        o_alu_en = 1'b1;
        if (r_ctl.ld | r_ctl.st) begin
          w_state_nxt = S_MEM;
        end else if (r_ctl.call) begin
          o_rf_we  = 1'b1;
          o_wb_sel = WB_PC4;
          o_pc_we  = 1'b1;
          o_pc_sel = PC_BR;
        end else if (r_ctl.ret) begin
          o_pc_we  = 1'b1;
          o_pc_sel = PC_RET;
        end else if (r_ctl.beq | r_ctl.bgt | r_ctl.ubr) begin
          o_pc_we  = 1'b1;
          o_pc_sel = w_taken ? PC_BR : PC_SEQ;
        end else if (r_ctl.wb) begin
          w_state_nxt = S_WB;
        end else begin
          o_pc_we = 1'b1;
        end
      end
      S_MEM: begin
        mem_if.dmem_req = 1'b1;
        mem_if.dmem_we  = r_ctl.st;
        if (mem_if.dmem_ready) begin
          if (r_ctl.ld) w_state_nxt = S_WB;
          else          o_pc_we     = 1'b1;
        end else if (r_wait == WAIT_LAST) begin
          w_state_nxt = S_ERR;
        end else begin
          w_wait_nxt = r_wait + WAIT_W'(1);
        end
      end
      S_WB: begin
        o_rf_we  = 1'b1;
        o_wb_sel = r_ctl.ld ? WB_MEM : WB_ALU;
        o_pc_we  = 1'b1;
      end
      S_ERR: begin
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A PC update retires the instruction; run is only honoured here.
    if (o_pc_we) begin
      w_state_nxt = i_run ? S_FETCH : S_IDLE;
      w_ctl_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_wait        <= '0;
      r_ctl         <= '0;
      r_retired_cnt <= '0;
      r_err         <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      r_ctl   <= w_ctl_nxt;
      r_err   <= r_err | (w_state_nxt == S_ERR);
      if (o_pc_we) r_retired_cnt <= r_retired_cnt + CNT_W'(1);
    end
  end

  assign o_busy        = (r_state != S_IDLE) && (r_state != S_ERR);
  assign o_err         = r_err;
  assign o_retired_cnt = r_retired_cnt;

endmodule
